// File: rtl/pu_seq_if.sv
// pu_seq_if: unified single-port memory request bus shared by instruction fetch and load/store
interface pu_seq_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_rdy;
  modport master (output mem_req, mem_we, mem_sel, input mem_rdy);
  modport slave (input mem_req, mem_we, mem_sel, output mem_rdy);
endinterface

// File: rtl/pu_seq.sv
// pu_seq: multicycle fetch/execute sequencer gating IR latch, register-file write and PC update
// with halt, run/single-step control and a sticky memory-timeout error.
module pu_seq #(
  parameter int TO_MAX = 255,
  parameter int TO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_dec_h,
  input  logic             i_dec_we,
  input  logic             i_dec_dmwe,
  input  logic             i_dec_dms,
  pu_seq_if.master         mem,
  output logic             o_ir_we,
  output logic             o_rf_we,
  output logic             o_pc_en,
  output logic             o_halted,
  output logic             o_err,
  output logic [CNT_W-1:0] o_icnt
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
  state_t r_st, w_nxt, w_done;
  logic r_req, r_sel, r_we;
  logic [TO_W-1:0] r_to;
  logic w_to_hit, w_commit;
  assign w_to_hit = r_req && !mem.mem_rdy && r_to == TO_W'(TO_MAX - 1);
  assign w_commit = (r_st == EXEC && !i_dec_h && !i_dec_dmwe && !i_dec_dms) || (r_st == MEM && mem.mem_rdy);
  assign w_done = i_run ? FETCH : IDLE;
  assign o_ir_we = r_st == FETCH && mem.mem_rdy;
  assign o_pc_en = w_commit;
  assign o_rf_we = w_commit && i_dec_we;
  assign mem.mem_req = r_req;
  assign mem.mem_sel = r_sel;
  assign mem.mem_we = r_we;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE:    w_nxt = (i_run || i_step) ? FETCH : IDLE;
      FETCH:   w_nxt = w_to_hit ? HALT : mem.mem_rdy ? EXEC : FETCH;
      EXEC:    w_nxt = i_dec_h ? HALT : (i_dec_dmwe || i_dec_dms) ? MEM : w_done;
      MEM:     w_nxt = w_to_hit ? HALT : mem.mem_rdy ? w_done : MEM;
      default: w_nxt = HALT;
    endcase
  end
  // bus outputs are registered from the next state so they are glitch-free at the memory port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_req    <= 1'b0;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_to     <= '0;
      o_halted <= 1'b0;
      o_err    <= 1'b0;
      o_icnt   <= '0;
    end else begin
      r_st     <= w_nxt;
      r_req    <= w_nxt == FETCH || w_nxt == MEM;
      r_sel    <= w_nxt == MEM;
      r_we     <= w_nxt == MEM && i_dec_dmwe;
      r_to     <= w_nxt != r_st ? '0 : (r_req && !mem.mem_rdy) ? r_to + 1'b1 : r_to;
      o_halted <= w_nxt == HALT;
      o_err    <= o_err || w_to_hit;
      if (w_commit) o_icnt <= o_icnt + 1'b1;
    end
  end
endmodule

// File: doc/pu_seq.md
Name: pu_seq

Overview:
Multicycle fetch/execute sequencer for the 16-bit educational PU. It shares one unified single-port memory between instruction fetch and data load/store. It latches the instruction register, gates the decoder's register-write and PC-write strobes so each fires once per instruction, and handles halt, run/single-step, and memory-timeout errors. It sits between the decoder outputs and the register file, PC, and memory port.

Parameters:
TO_MAX, 255, max cycles mem_req may stay unanswered before error
TO_W, 8, width of timeout counter (must hold TO_MAX)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = free-run, 0 = stop at instruction boundary
step  in  1  one-cycle pulse; executes one instruction when run=0
dec_h  in  1  decoder halt
dec_we  in  1  decoder register-write request
dec_dmwe  in  1  decoder data-memory write (store)
dec_dms  in  1  decoder data-memory select (load result to register)
mem_rdy  in  1  memory completion for current request
mem_req  out  1  memory request
mem_we  out  1  memory write strobe (valid with mem_req)
mem_sel  out  1  0 = instruction address (PC), 1 = data address
ir_we  out  1  latch memory read data into instruction register
rf_we  out  1  gated register-file write enable
pc_en  out  1  gated PC update enable
halted  out  1  sequencer stopped in HALT
err  out  1  sticky memory-timeout error
icnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; all outputs 0; icnt=0; timeout counter=0. Reset mid-request drops mem_req immediately, with no handshake completion.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE: all strobes 0.
  - If run=1, or step=1 sampled, go to FETCH.
  - step pulses in any other state are ignored, not queued.
- FETCH: mem_req=1, mem_sel=0, mem_we=0.
  - In the cycle mem_rdy=1: ir_we=1, then go to EXEC.
  - mem_rdy may be 1 in the first FETCH cycle, giving a minimum of 1 cycle.
- EXEC: decoder inputs are valid from the latched IR. Priority:
  - dec_h=1: go to HALT. No rf_we, no pc_en, icnt unchanged.
  - dec_dmwe=1 or dec_dms=1: go to MEM.
  - Otherwise commit in this cycle: rf_we=dec_we, pc_en=1, icnt+1. Then go to FETCH if run=1, else IDLE.
- MEM: mem_req=1, mem_sel=1, mem_we=dec_dmwe. dec_dmwe wins over dec_dms if both are 1.
  - In the cycle mem_rdy=1: commit with rf_we=dec_we, pc_en=1, icnt+1. Then go to FETCH if run=1, else IDLE.
- Commit strobes (rf_we, pc_en, ir_we) are exactly one cycle wide, at most once per instruction.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each cycle that mem_req=1 with mem_rdy=0.
  - When it reaches TO_MAX: err=1, go to HALT, mem_req drops the next cycle, no commit.
  - mem_rdy outside FETCH/MEM is ignored.
- HALT: halted=1, all strobes 0. Stays until reset. run and step are ignored. err holds its value.
- icnt wraps modulo 2^CNT_W.
- Dropping run mid-instruction completes the current instruction, then parks in IDLE.
- Instruction timing with mem_rdy immediate: ALU/LI takes 2 cycles (FETCH, EXEC); load/store takes 3 (FETCH, EXEC, MEM).

Test Plan:
- Reset, run=1, mem_rdy tied 1, IR stream of 3 non-memory instructions with dec_we=1 → pc_en/rf_we pulse on cycles 2, 4, 6; icnt=3; mem_sel always 0.
- Store: dec_dmwe=1, mem_rdy delayed 3 cycles in MEM → mem_req held 4 cycles with mem_sel=1, mem_we=1; then a single pc_en pulse with rf_we=0.
- run=0, one step pulse → exactly one instruction retires (icnt 0→1) and the FSM returns to IDLE; a second step during EXEC is ignored.
- dec_h=1 in EXEC → halted=1 next cycle; pc_en never pulses; step and run toggles keep halted=1 and icnt unchanged.
- TO_MAX=4, mem_rdy held 0 in FETCH → err=1 and halted=1 after 4 request cycles; mem_req low afterwards.
- rst_n pulsed low during MEM with mem_req=1 → mem_req=0 asynchronously; icnt=0; state IDLE; no pc_en pulse.
